// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: shares one AXI write slave port between two write masters.
// One whole transaction (AW -> W beats -> B) is granted at a time; the grant
// is chosen round-robin so the master just served loses priority next time.
// Optional build macro WARB_BEATCHK_EN: adds a W beat counter and a sticky
// len_err output flagging bursts whose beat count disagrees with AWLEN.
module axi_write_arbiter #(
  parameter int buswidth = 32,
  parameter int NM       = 2
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [43*NM-1:0]           m_awinfo,
  input  logic [NM-1:0]              m_awvalid,
  output logic [NM-1:0]              m_awready,
  input  logic [NM*buswidth-1:0]     m_wdata,
  input  logic [NM*(buswidth/8)-1:0] m_wstrb,
  input  logic [NM-1:0]              m_wlast,
  input  logic [NM-1:0]              m_wvalid,
  output logic [NM-1:0]              m_wready,
  output logic [1:0]                 m_bid,
  output logic [1:0]                 m_bresp,
  output logic [NM-1:0]              m_bvalid,
  input  logic [NM-1:0]              m_bready,
  output logic [42:0]                s_awinfo,
  output logic                       s_awvalid,
  input  logic                       s_awready,
  output logic [buswidth-1:0]        s_wdata,
  output logic [buswidth/8-1:0]      s_wstrb,
  output logic                       s_wlast,
  output logic                       s_wvalid,
  input  logic                       s_wready,
  input  logic [1:0]                 s_bid,
  input  logic [1:0]                 s_bresp,
  input  logic                       s_bvalid,
  output logic                       s_bready
`ifdef WARB_BEATCHK_EN
  ,
  output logic                       len_err
`endif
);

  localparam int SW = buswidth / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_g, w_g_nxt;   // granted master
  logic   r_p, w_p_nxt;   // master holding priority for the next arbitration

  // State, grant and priority registers; reset forces IDLE so every valid/ready drops at once.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
      r_g     <= 1'b0;
      r_p     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_p     <= w_p_nxt;
    end
  end

  // Next state, grant selection and handshake routing between master g and the slave.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_p_nxt     = r_p;
    s_awvalid   = 1'b0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    m_awready   = '0;
    m_wready    = '0;
    m_bvalid    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (|m_awvalid) begin
          w_g_nxt     = m_awvalid[r_p] ? r_p : ~r_p;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_awvalid          = m_awvalid[r_g];
        m_awready[r_g]     = s_awready;
        if (s_awvalid && s_awready) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        s_wvalid           = m_wvalid[r_g];
        m_wready[r_g]      = s_wready;
        if (s_wvalid && s_wready && s_wlast) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        m_bvalid[r_g]      = s_bvalid;
        s_bready           = m_bready[r_g];
        if (s_bvalid && s_bready) begin
          w_state_nxt = ST_IDLE;
          w_p_nxt     = ~r_g;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Payloads are plain muxes on the grant; the valids above give them meaning.
  assign s_awinfo = r_g ? m_awinfo[43 +: 43]        : m_awinfo[0 +: 43];
  assign s_wdata  = r_g ? m_wdata[buswidth +: buswidth] : m_wdata[0 +: buswidth];
  assign s_wstrb  = r_g ? m_wstrb[SW +: SW]          : m_wstrb[0 +: SW];
  assign s_wlast  = m_wlast[r_g];
  assign m_bid    = s_bid;
  assign m_bresp  = s_bresp;

`ifdef WARB_BEATCHK_EN
  logic [3:0] r_awlen;
  logic [4:0] r_beat_cnt;
  logic       r_len_err;
  logic [4:0] w_beat_num;
  logic [4:0] w_exp_beats;

  assign w_beat_num  = r_beat_cnt + 5'd1;
  assign w_exp_beats = {1'b0, r_awlen} + 5'd1;

  // Beat counter: AWLEN latched at the AW handshake, a mismatch between WLAST and the count is sticky.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_awlen    <= 4'd0;
      r_beat_cnt <= 5'd0;
      r_len_err  <= 1'b0;
    end else begin
      if (r_state == ST_ADDR) r_beat_cnt <= 5'd0;
      if (r_state == ST_ADDR && s_awvalid && s_awready) r_awlen <= s_awinfo[8:5];
      if (r_state == ST_DATA && s_wvalid && s_wready) begin
        r_beat_cnt <= w_beat_num;
        // WLAST must arrive exactly on beat AWLEN+1: early, late or missing all flag.
        if (s_wlast != (w_beat_num == w_exp_beats)) r_len_err <= 1'b1;
      end
    end
  end

  assign len_err = r_len_err;
`endif

endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb_axi_write_arbiter: transaction-level scoreboard bench for axi_write_arbiter.
// A driver process plays both masters and the slave; a monitor process keeps a
// round-robin reference of whole transactions and checks routing every cycle.
module tb_axi_write_arbiter;

  localparam int BW = 32;

  typedef struct packed {
    logic [42:0] info;
    logic [31:0] seed;
    logic [4:0]  nsent;   // beats the master actually sends, WLAST on the last
  } txn_t;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [85:0] m_awinfo;
  logic [1:0]  m_awvalid, m_awready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_wlast, m_wvalid, m_wready;
  logic [1:0]  m_bid, m_bresp, m_bvalid, m_bready;
  logic [42:0] s_awinfo;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast, s_wvalid, s_wready;
  logic [1:0]  s_bid, s_bresp;
  logic        s_bvalid, s_bready;
`ifdef WARB_BEATCHK_EN
  logic        len_err;
`endif

  always #5 ACLK = ~ACLK;

  axi_write_arbiter #(.buswidth(BW), .NM(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_awinfo(m_awinfo), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awinfo(s_awinfo), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
`ifdef WARB_BEATCHK_EN
    , .len_err(len_err)
`endif
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  txn_t src_q [2][$];   // transactions each master still has to issue
  txn_t exp_q [2][$];   // issued transactions awaiting the slave side

  int   slave_mode;     // 0 always ready, 1 random, 2 s_wready toggles
  bit   mst_rand;
  int   gap_max;

  int   drv_ph   [2];
  int   drv_beat [2];
  int   drv_gap  [2];
  txn_t drv_cur  [2];
  bit   b_pend;

  int   mon_ph, mon_w, mon_p, mon_idx, mon_done;
  txn_t mon_cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] seed, input int k);
    return seed ^ (32'(k) * 32'h9E37_79B9);
  endfunction

  function automatic logic [3:0] beat_strb(input logic [31:0] seed, input int k);
    return seed[3:0] + k[3:0];
  endfunction

  function automatic txn_t mk_txn(input logic [1:0] id, input logic [31:0] addr,
                                  input logic [3:0] len, input logic [31:0] seed);
    txn_t t;
    t.info  = {id, addr, len, 3'd2, 2'd1};
    t.seed  = seed;
    t.nsent = {1'b0, len} + 5'd1;
    return t;
  endfunction

  task automatic clear_drivers();
    m_awinfo = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0;
    m_wlast = '0; m_wvalid = '0; m_bready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
    b_pend = 1'b0;
    for (int m = 0; m < 2; m++) begin
      drv_ph[m] = 0; drv_beat[m] = 0; drv_gap[m] = 0;
      src_q[m].delete();
    end
  endtask

  // One clock of both master engines and the slave model.
  task automatic step();
    logic [1:0] aw_hs, w_hs, b_hs;
    logic       sw_last_hs, sb_hs;
    @(negedge ACLK);
    aw_hs      = m_awvalid & m_awready;
    w_hs       = m_wvalid & m_wready;
    b_hs       = m_bvalid & m_bready;
    sw_last_hs = s_wvalid & s_wready & s_wlast;
    sb_hs      = s_bvalid & s_bready;
    @(posedge ACLK);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (drv_ph[m] == 1 && aw_hs[m]) begin
        m_awvalid[m] = 1'b0; drv_beat[m] = 0; m_wvalid[m] = 1'b0; drv_ph[m] = 2;
      end else if (drv_ph[m] == 2) begin
        if (w_hs[m]) drv_beat[m]++;
        if (drv_beat[m] == int'(drv_cur[m].nsent)) begin
          m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0; drv_ph[m] = 3;
        end
      end
      if (drv_ph[m] == 2 && !(m_wvalid[m] && !w_hs[m])) begin
        m_wdata[32*m +: 32] = beat_data(drv_cur[m].seed, drv_beat[m]);
        m_wstrb[4*m +: 4]   = beat_strb(drv_cur[m].seed, drv_beat[m]);
        m_wlast[m]          = (drv_beat[m] == int'(drv_cur[m].nsent) - 1);
        m_wvalid[m]         = mst_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (drv_ph[m] == 3) begin
        if (b_hs[m]) begin
          m_bready[m] = 1'b0; drv_ph[m] = 0;
          drv_gap[m]  = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        end else begin
          m_bready[m] = mst_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
      end
      if (drv_ph[m] == 0 && src_q[m].size() > 0) begin
        if (drv_gap[m] > 0) drv_gap[m]--;
        else begin
          drv_cur[m] = src_q[m].pop_front();
          exp_q[m].push_back(drv_cur[m]);
          m_awinfo[43*m +: 43] = drv_cur[m].info;
          m_awvalid[m] = 1'b1;
          drv_ph[m] = 1;
        end
      end
    end
    if (sb_hs) s_bvalid = 1'b0;
    if (sw_last_hs) b_pend = 1'b1;
    if (b_pend && !s_bvalid && (slave_mode != 1 || $urandom_range(0, 1) == 1)) begin
      s_bvalid = 1'b1; s_bid = 2'($urandom); s_bresp = 2'($urandom); b_pend = 1'b0;
    end
    case (slave_mode)
      0:       begin s_awready = 1'b1; s_wready = 1'b1; end
      1:       begin s_awready = ($urandom_range(0, 2) != 0); s_wready = ($urandom_range(0, 2) != 0); end
      default: begin s_awready = 1'b1; s_wready = ~s_wready; end
    endcase
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && drv_ph[0] == 0 &&
             drv_ph[1] == 0 && mon_ph == 0 && !b_pend && !s_bvalid) && n < 5000) begin
      step();
      n++;
    end
    check(name, 64'(n < 5000), 64'd1);
  endtask

  task automatic apply_reset();
    ARESETn = 1'b0;
    clear_drivers();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
  endtask

  // Monitor: transaction-level round-robin reference and per-cycle routing checks.
  initial begin
    logic [8:0] route;
    logic       e_awv, e_wv, e_br;
    logic [1:0] e_awr, e_wr, e_bv, oh;
    mon_ph = 0; mon_p = 0; mon_w = 0; mon_idx = 0; mon_done = 0; mon_cur = '0;
    forever begin
      @(negedge ACLK);
      route = {s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid};
      if (!ARESETn) begin
        check("reset_quiet", 64'(route), 64'd0);
        mon_ph = 0; mon_p = 0; mon_w = 0;
        exp_q[0].delete(); exp_q[1].delete();
      end else begin
        oh = 2'b01 << mon_w;
        e_awv = 1'b0; e_wv = 1'b0; e_br = 1'b0; e_awr = '0; e_wr = '0; e_bv = '0;
        case (mon_ph)
          1: begin e_awv = m_awvalid[mon_w]; e_awr = s_awready ? oh : 2'b00; end
          2: begin e_wv  = m_wvalid[mon_w];  e_wr  = s_wready  ? oh : 2'b00; end
          3: begin e_br  = m_bready[mon_w];  e_bv  = s_bvalid  ? oh : 2'b00; end
          default: ;
        endcase
        check("route", 64'(route), 64'({e_awv, e_wv, e_br, e_awr, e_wr, e_bv}));
        check("aw_b_payload", 64'({s_awinfo, m_bid, m_bresp}),
              64'({m_awinfo[43*mon_w +: 43], s_bid, s_bresp}));
        check("w_payload", 64'({s_wdata, s_wstrb, s_wlast}),
              64'({m_wdata[32*mon_w +: 32], m_wstrb[4*mon_w +: 4], m_wlast[mon_w]}));
        case (mon_ph)
          0: if (|m_awvalid) begin
               mon_w  = m_awvalid[mon_p] ? mon_p : 1 - mon_p;
               mon_ph = 1;
             end
          1: if (s_awvalid && s_awready) begin
               check("exp_q_depth", 64'(exp_q[mon_w].size()), 64'd1);
               mon_cur = (exp_q[mon_w].size() > 0) ? exp_q[mon_w].pop_front() : '0;
               check("awinfo", 64'(s_awinfo), 64'(mon_cur.info));
               mon_idx = 0;
               mon_ph  = 2;
             end
          2: if (s_wvalid && s_wready) begin
               check("wbeat", 64'({s_wdata, s_wstrb, s_wlast}),
                     64'({beat_data(mon_cur.seed, mon_idx), beat_strb(mon_cur.seed, mon_idx),
                          1'(mon_idx == int'(mon_cur.nsent) - 1)}));
               mon_idx++;
               if (s_wlast) mon_ph = 3;
             end
          3: if (s_bvalid && s_bready) begin
               mon_p  = 1 - mon_w;
               mon_ph = 0;
               mon_done++;
             end
          default: mon_ph = 0;
        endcase
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int   n;
    int   done0;
    txn_t t;
    slave_mode = 0; mst_rand = 1'b0; gap_max = 0;
    ARESETn = 1'b0;
    clear_drivers();
    #1;
    check("reset_outputs", 64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'd0);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    #2 ARESETn = 1'b1;

    // Master 0 alone, 4-beat burst at 0x100, slave always ready.
    src_q[0].push_back(mk_txn(2'd1, 32'h0000_0100, 4'd3, 32'hA5A5_0001));
    drain("drain_m0_single");

    // Priority now rests with master 1: a simultaneous request serves master 1 first.
    src_q[0].push_back(mk_txn(2'd0, 32'h0000_1000, 4'd1, 32'h1111_0000));
    src_q[1].push_back(mk_txn(2'd2, 32'h0000_2000, 4'd2, 32'h2222_0000));
    drain("drain_both_p1");

    // After reset, simultaneous requests serve master 0 first.
    apply_reset();
    src_q[0].push_back(mk_txn(2'd0, 32'h0000_3000, 4'd2, 32'h3333_0000));
    src_q[1].push_back(mk_txn(2'd3, 32'h0000_4000, 4'd1, 32'h4444_0000));
    drain("drain_both_after_reset");

    // Master 1 issues three back-to-back single-beat writes.
    done0 = mon_done;
    for (int i = 0; i < 3; i++)
      src_q[1].push_back(mk_txn(2'(i), 32'h0000_5000 + 32'(i * 4), 4'd0, 32'h5550_0000 + 32'(i)));
    drain("drain_m1_b2b");
    check("m1_b2b_count", 64'(mon_done - done0), 64'd3);

    // s_wready toggles every cycle through a 4-beat burst.
    slave_mode = 2;
    done0 = mon_done;
    src_q[0].push_back(mk_txn(2'd1, 32'h0000_6000, 4'd3, 32'h6666_0000));
    drain("drain_toggle");
    check("toggle_count", 64'(mon_done - done0), 64'd1);

    // Randomised traffic from both masters.
    slave_mode = 1; mst_rand = 1'b1; gap_max = 3;
    done0 = mon_done;
    for (int i = 0; i < 20; i++)
      for (int m = 0; m < 2; m++)
        src_q[m].push_back(mk_txn(2'($urandom), $urandom, 4'($urandom_range(0, 7)), $urandom));
    drain("drain_random");
    check("random_count", 64'(mon_done - done0), 64'd40);

    // Reset asserted mid-burst: outputs must drop without waiting for a clock.
    slave_mode = 0; mst_rand = 1'b0; gap_max = 0;
    src_q[0].push_back(mk_txn(2'd0, 32'h0000_7000, 4'd7, 32'h7777_0000));
    n = 0;
    while (!(mon_ph == 2 && mon_idx >= 1) && n < 500) begin
      step();
      n++;
    end
    check("reach_data", 64'(n < 500), 64'd1);
    check("pre_reset_wvalid", 64'(s_wvalid), 64'd1);
    #1 ARESETn = 1'b0;
    #1;
    check("async_reset_route", 64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'd0);
    clear_drivers();
    @(negedge ACLK);
    @(posedge ACLK);
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
    done0 = mon_done;
    src_q[1].push_back(mk_txn(2'd2, 32'h0000_8000, 4'd1, 32'h8888_0000));
    drain("drain_after_midreset");
    check("midreset_fresh_count", 64'(mon_done - done0), 64'd1);

`ifdef WARB_BEATCHK_EN
    check("len_err_clear", 64'(len_err), 64'd0);
    t = mk_txn(2'd0, 32'h0000_9000, 4'd3, 32'h9999_0000);
    t.nsent = 5'd2;
    src_q[0].push_back(t);
    drain("drain_short_burst");
    check("len_err_set", 64'(len_err), 64'd1);
    src_q[1].push_back(mk_txn(2'd1, 32'h0000_A000, 4'd3, 32'hAAAA_0000));
    drain("drain_good_after_err");
    check("len_err_sticky", 64'(len_err), 64'd1);
`else
    t = '0;
`endif

    repeat (2) @(posedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
